serial_adder: RTL and testbench

//  Bit-serial unsigned adder built around one half-adder-pair (full-adder) cell and a carry flip-flop.

---
 rtl/serial_adder.sv | 208 ++++++++++++++++++++
 tb/tb_serial_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder. A single full-adder cell (built
// from two half-adder stages) plus a carry flip-flop adds one bit per clock,
// LSB first. Operands arrive over an in_valid/in_ready handshake; the
// WIDTH-bit sum and carry-out leave over an out_valid/out_ready handshake.
// Optional build macro: SERIAL_ADDER_SAT_EN saturates the sum to all ones
// when the final carry is set (cout still reports the carry).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic [CNT_W-1:0] cnt_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;

  logic             last_bit_s;
  logic             prop_s;
  logic             gen_s;
  logic             bit_sum_s;
  logic             carry_next_s;
  logic [WIDTH-1:0] sum_shift_s;

  // Half-adder sum term.
  function automatic logic ha_sum(input logic x, input logic y);
    return x ^ y;
  endfunction

  // Half-adder carry term.
  function automatic logic ha_carry(input logic x, input logic y);
    return x & y;
  endfunction

  // Full-adder cell from two half adders, plus the shifted sum image.
  always_comb begin
    prop_s       = ha_sum(a_sh_r[0], b_sh_r[0]);
    gen_s        = ha_carry(a_sh_r[0], b_sh_r[0]);
    bit_sum_s    = ha_sum(prop_s, carry_r);
    carry_next_s = gen_s | ha_carry(prop_s, carry_r);
    sum_shift_s  = {bit_sum_s, sum_r[WIDTH-1:1]};
    last_bit_s   = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: accept in IDLE, count through RUN, release in DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the handshake flags are registered.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        in_ready_s = 1'b1;
      end
      ST_RUN: begin
        busy_s = 1'b1;
      end
      ST_DONE: begin
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b1;
      end
    endcase
  end

  // Registered handshake and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  // Datapath: latch operands on accept, then shift one bit per clock in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        ST_RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= carry_next_s;
          cnt_r   <= cnt_r + CNT_W'(1'b1);
          if (last_bit_s) begin
            cout_r <= carry_next_s;
`ifdef SERIAL_ADDER_SAT_EN
            if (carry_next_s) begin
              sum_r <= {WIDTH{1'b1}};
            end else begin
              sum_r <= sum_shift_s;
            end
`else
            sum_r <= sum_shift_s;
`endif
          end else begin
            sum_r <= sum_shift_s;
          end
        end
        ST_DONE: begin
          sum_r  <= sum_r;
          cout_r <= cout_r;
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vectors with
// literal expectations plus a cycle-count model checked every cycle.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: phase 0 idle, 1 computing, 2 result held.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [W:0]   m_pend  = '0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  int           m_ops   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the result is a+b+cin, visible exactly W edges after acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_phase <= 1;
          m_left  <= W;
          m_pend  <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
          m_ops   <= m_ops + 1;
        end
        1: if (m_left == 1) begin
          m_phase <= 2;
          m_cout  <= m_pend[W];
`ifdef SERIAL_ADDER_SAT_EN
          m_sum   <= m_pend[W] ? {W{1'b1}} : m_pend[W-1:0];
`else
          m_sum   <= m_pend[W-1:0];
`endif
        end else begin
          m_left <= m_left - 1;
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, (m_phase == 0));
      check("busy", busy, (m_phase == 1));
      check("out_valid", out_valid, (m_phase == 2));
      if (m_phase != 1) begin
        check("sum", sum, m_sum);
        check("cout", cout, m_cout);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One operation with literal expectations; stall = cycles of out_ready low in DONE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] es, input logic ec, input int stall);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check("op_in_ready_wait", in_ready, 1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin n++; step(); end
    check("op_latency", n, W);
    check("op_sum", sum, es);
    check("op_cout", cout, ec);
    if (stall > 0) begin
      repeat (stall) step();
      check("stall_out_valid", out_valid, 1);
      check("stall_sum", sum, es);
      check("stall_in_ready", in_ready, 0);
      out_ready = 1'b1;
    end
    step();
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [W-1:0] sat_ff;
    logic [W-1:0] sat_80;
    int           start_ops;
    int           cyc;
`ifdef SERIAL_ADDER_SAT_EN
    sat_ff = 8'hFF; sat_80 = 8'hFF;
`else
    sat_ff = 8'h00; sat_80 = 8'h00;
`endif
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    chk_en = 1'b1;
    repeat (2) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, sat_ff, 1'b1, 0);
    run_op(8'h80, 8'h7F, 1'b1, sat_80, 1'b1, 5);

    // Operand changes and in_valid pulses during RUN must be ignored.
    a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    a = 8'h11; b = 8'h00; in_valid = 1'b0;
    step();
    in_valid = 1'b1; step(); step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin cyc++; step(); end
    check("ignore_sum", sum, 8'h03);
    check("ignore_cout", cout, 0);
    step();
    check("ignore_idle", in_ready, 1);
    repeat (3) step();
    check("ignore_no_accept", busy, 0);

    // Reset three cycles into RUN discards the partial result.
    a = 8'h33; b = 8'h44; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_sum", sum, 8'h00);
    step();
    rst = 1'b0;
    repeat (10) step();
    check("abort_no_valid", out_valid, 0);
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);

    // 1000 random operations with random backpressure, checked by the model.
    start_ops = m_ops;
    cyc = 0;
    while ((m_ops - start_ops) < 1000 && cyc < 40000) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom);
      step();
      cyc++;
    end
    check("random_ops_done", ((m_ops - start_ops) >= 1000), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (W + 4) step();
    check("drain_idle", in_ready, 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
